mem_port_arbiter: RTL and testbench

//  Shares one single-ported 64-bit memory between the fetch path (instruction reads) and the MEM stage (loads/stores).

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the fetch/data memory port arbiter
package mem_arb_pkg;

  // Transaction sequencer states: issue in IDLE, hold request in REQ, await response in WAIT
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  // Which requester owns the transaction currently in flight
  typedef enum logic [1:0] {
    NONE = 2'd0,
    IF   = 2'd1,
    DM   = 2'd2
  } owner_e;

  // Address bit that selects the upper or lower 32-bit instruction inside a 64-bit memory word
  localparam int FETCH_WORD_SEL = 2;

  // Extract the addressed instruction word from a 64-bit memory word
  function automatic logic [31:0] fetch_word(input logic [63:0] line, input logic hi);
    return hi ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter sharing one memory port between fetch and data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e       state;
  arb_state_e       state_nxt;
  owner_e           owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             kill_pend;
  logic             fetch_hi;

  logic             if_elig;
  logic             force_if;
  logic             grant_if;
  logic             grant_dm;
  logic             resp_fire;

  // Byte-offset bits of a word-aligned fetch address carry no information
  logic             unused_if_addr;
  assign unused_if_addr = ^if_addr[FETCH_WORD_SEL-1:0];

  // Arbitration decode: data side wins ties unless fetch has been starved long enough
  always_comb begin
    if_elig  = if_req & ~if_kill;
    force_if = if_elig & (starve_cnt == CNT_MAX);
    grant_if = (state == IDLE) & if_elig & (~dm_req | force_if);
    grant_dm = (state == IDLE) & dm_req & ~force_if;
    resp_fire = (state == WAIT) & mem_rvalid;
  end

  // Next-state logic for the issue / accept / response sequence
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_if | grant_dm) state_nxt = REQ;
      REQ:     if (mem_ready)           state_nxt = WAIT;
      WAIT:    if (mem_rvalid)          state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // State register, registered memory request, ownership, starvation counter and kill tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= NONE;
      starve_cnt <= '0;
      kill_pend  <= 1'b0;
      fetch_hi   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            owner     <= DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (if_req && (starve_cnt != CNT_MAX)) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end else if (grant_if) begin
            owner      <= IF;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= {if_addr[ADDR_W-1:FETCH_WORD_SEL+1], {(FETCH_WORD_SEL+1){1'b0}}};
            mem_wdata  <= '0;
            fetch_hi   <= if_addr[FETCH_WORD_SEL];
            starve_cnt <= '0;
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
          end
          if ((owner == IF) && if_kill) begin
            kill_pend <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            owner     <= NONE;
            kill_pend <= 1'b0;
          end else if ((owner == IF) && if_kill) begin
            kill_pend <= 1'b1;
          end
        end
        default: begin
          owner   <= NONE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Response steering and stall requests; a killed fetch completes on the bus but is never reported
  always_comb begin
    if_rvalid = resp_fire & (owner == IF) & ~kill_pend & ~if_kill;
    dm_rvalid = resp_fire & (owner == DM);
    if_rdata  = if_rvalid ? fetch_word(mem_rdata, fetch_hi) : 32'd0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
    stall_if  = if_req & ~if_rvalid;
    stall_mem = dm_req & ~dm_rvalid;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_kill;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_rvalid;
  logic [63:0] dm_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  int n_checks;
  int n_pass;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    if_req     = 1'b0;
    if_addr    = '0;
    if_kill    = 1'b0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = '0;
    dm_wdata   = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // reset state
    tick();
    tick();
    check("rst_state", 64'(dut.state), 64'(IDLE));
    check("rst_owner", 64'(dut.owner), 64'(NONE));
    check("rst_starve", 64'(dut.starve_cnt), 64'd0);
    check("rst_kill", 64'(dut.kill_pend), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    check("rst_dm_rvalid", 64'(dm_rvalid), 64'd0);
    rst = 1'b0;

    // fetch only, 1-cycle memory: response in the third cycle, upper word selected
    if_req = 1'b1; if_addr = 64'h1004; mem_ready = 1'b1;
    mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    check("f1_stall_if", 64'(stall_if), 64'd1);
    tick();
    check("f1_state_req", 64'(dut.state), 64'(REQ));
    check("f1_mem_req", 64'(mem_req), 64'd1);
    check("f1_mem_addr", mem_addr, 64'h1000);
    check("f1_mem_we", 64'(mem_we), 64'd0);
    check("f1_no_early_rvalid", 64'(if_rvalid), 64'd0);
    tick();
    check("f1_state_wait", 64'(dut.state), 64'(WAIT));
    check("f1_mem_req_drop", 64'(mem_req), 64'd0);
    mem_rvalid = 1'b1;
    #1;
    check("f1_if_rvalid", 64'(if_rvalid), 64'd1);
    check("f1_if_rdata", 64'(if_rdata), 64'hAAAA_BBBB);
    check("f1_stall_if_off", 64'(stall_if), 64'd0);
    tick();
    if_req = 1'b0; mem_rvalid = 1'b0;
    #1;
    check("f1_back_idle", 64'(dut.state), 64'(IDLE));
    check("f1_rvalid_one_pulse", 64'(if_rvalid), 64'd0);

    // simultaneous requests: data first, fetch issued in the IDLE cycle after the load response
    if_req = 1'b1; if_addr = 64'h300C;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h2000;
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    check("s_dm_first_addr", mem_addr, 64'h2000);
    check("s_owner_dm", 64'(dut.owner), 64'(DM));
    check("s_starve_1", 64'(dut.starve_cnt), 64'd1);
    check("s_stall_if_a", 64'(stall_if), 64'd1);
    tick();
    check("s_stall_if_b", 64'(stall_if), 64'd1);
    mem_rvalid = 1'b1;
    #1;
    check("s_dm_rvalid", 64'(dm_rvalid), 64'd1);
    check("s_dm_rdata", dm_rdata, 64'h0123_4567_89AB_CDEF);
    check("s_if_rvalid_no", 64'(if_rvalid), 64'd0);
    check("s_stall_if_c", 64'(stall_if), 64'd1);
    check("s_stall_mem_off", 64'(stall_mem), 64'd0);
    tick();
    dm_req = 1'b0; mem_rvalid = 1'b0;
    #1;
    check("s_idle_gap", 64'(mem_req), 64'd0);
    check("s_stall_if_d", 64'(stall_if), 64'd1);
    tick();
    check("s_fetch_addr", mem_addr, 64'h3008);
    check("s_starve_clr", 64'(dut.starve_cnt), 64'd0);
    tick();
    mem_rvalid = 1'b1;
    #1;
    check("s_if_rvalid", 64'(if_rvalid), 64'd1);
    check("s_if_rdata", 64'(if_rdata), 64'h0123_4567);
    tick();
    if_req = 1'b0; mem_rvalid = 1'b0;

    // starvation: data held continuously, fetch forced after four data wins
    if_req = 1'b1; if_addr = 64'h4000;
    dm_req = 1'b1; dm_addr = 64'h5000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_dm_addr", mem_addr, 64'h5000);
      check("st_starve_cnt", 64'(dut.starve_cnt), 64'(i + 1));
      tick();
      mem_rvalid = 1'b1;
      #1;
      check("st_dm_rvalid", 64'(dm_rvalid), 64'd1);
      tick();
      mem_rvalid = 1'b0;
    end
    tick();
    check("st_fetch_forced", mem_addr, 64'h4000);
    check("st_owner_if", 64'(dut.owner), 64'(IF));
    check("st_starve_zero", 64'(dut.starve_cnt), 64'd0);
    tick();
    mem_rdata = 64'h1357_9BDF_2468_ACE0;
    mem_rvalid = 1'b1;
    #1;
    check("st_if_rvalid", 64'(if_rvalid), 64'd1);
    check("st_if_rdata", 64'(if_rdata), 64'h2468_ACE0);
    check("st_dm_rvalid_no", 64'(dm_rvalid), 64'd0);
    tick();
    if_req = 1'b0; dm_req = 1'b0; mem_rvalid = 1'b0;

    // kill during WAIT: response swallowed, redirected fetch issues normally
    if_req = 1'b1; if_addr = 64'h6000;
    tick();
    tick();
    check("k_state_wait", 64'(dut.state), 64'(WAIT));
    if_kill = 1'b1;
    #1;
    check("k_no_rvalid_a", 64'(if_rvalid), 64'd0);
    tick();
    if_kill = 1'b0; if_addr = 64'h7004;
    #1;
    check("k_pend_set", 64'(dut.kill_pend), 64'd1);
    tick();
    mem_rdata = 64'h5555_6666_7777_8888;
    mem_rvalid = 1'b1;
    #1;
    check("k_suppressed", 64'(if_rvalid), 64'd0);
    check("k_stall_if", 64'(stall_if), 64'd1);
    tick();
    mem_rvalid = 1'b0;
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    check("k_pend_clr", 64'(dut.kill_pend), 64'd0);
    check("k_idle", 64'(dut.state), 64'(IDLE));
    tick();
    check("k_new_addr", mem_addr, 64'h7000);
    check("k_new_req", 64'(mem_req), 64'd1);
    tick();
    mem_rvalid = 1'b1;
    #1;
    check("k_new_rvalid", 64'(if_rvalid), 64'd1);
    check("k_new_rdata", 64'(if_rdata), 64'hDEAD_BEEF);
    tick();
    if_req = 1'b0; mem_rvalid = 1'b0;

    // kill in IDLE blocks issue for that cycle only
    if_req = 1'b1; if_kill = 1'b1; if_addr = 64'hA000;
    tick();
    check("ki_no_issue", 64'(mem_req), 64'd0);
    check("ki_idle", 64'(dut.state), 64'(IDLE));
    if_kill = 1'b0;
    tick();
    check("ki_issue", mem_addr, 64'hA000);
    tick();
    mem_rvalid = 1'b1;
    #1;
    check("ki_rvalid", 64'(if_rvalid), 64'd1);
    tick();
    if_req = 1'b0; mem_rvalid = 1'b0;

    // store with memory back-pressure: attributes stable while REQ is held
    mem_ready = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h8010;
    dm_wdata = 64'h1122_3344_5566_7788;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("w_mem_req", 64'(mem_req), 64'd1);
      check("w_mem_we", 64'(mem_we), 64'd1);
      check("w_mem_addr", mem_addr, 64'h8010);
      check("w_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
      check("w_stall_mem", 64'(stall_mem), 64'd1);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    check("w_accepted", 64'(mem_req), 64'd0);
    mem_rvalid = 1'b1;
    #1;
    check("w_dm_rvalid", 64'(dm_rvalid), 64'd1);
    check("w_stall_mem_off", 64'(stall_mem), 64'd0);
    tick();
    dm_req = 1'b0; dm_we = 1'b0; mem_rvalid = 1'b0;

    // reset mid-transaction, then a stray response is ignored
    mem_ready = 1'b0;
    if_req = 1'b1; if_addr = 64'h9000;
    tick();
    check("r_in_req", 64'(mem_req), 64'd1);
    rst = 1'b1;
    tick();
    check("r_mem_req_drop", 64'(mem_req), 64'd0);
    check("r_state_idle", 64'(dut.state), 64'(IDLE));
    check("r_kill_pend", 64'(dut.kill_pend), 64'd0);
    rst = 1'b0; if_req = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    check("r_stray_if", 64'(if_rvalid), 64'd0);
    check("r_stray_dm", 64'(dm_rvalid), 64'd0);
    tick();
    mem_rvalid = 1'b0;
    check("r_still_idle", 64'(dut.state), 64'(IDLE));
    check("r_no_req", 64'(mem_req), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
